ddr3_loopback_checker: RTL and testbench



---
 rtl/ddr3_loopback_checker.sv | 208 ++++++++++++++++++++
 tb/tb_ddr3_loopback_checker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_loopback_checker.sv
// DDR3 user-port loopback checker: writes a burst, reads it back in order, compares and reports.
// Optional macro CHECKER_LFSR_PATTERN_EN selects a 16-bit LFSR data pattern instead of k+1.
module ddr3_loopback_checker #(
  parameter int ADDRESS_BITWIDTH      = 15,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int DQ_BITWIDTH           = 16,
  parameter int NUM_OF_TEST_DATA      = 4,
  parameter int START_ADDRESS         = 0,
  parameter int TIMEOUT_CYCLES        = 65535
) (
  input  logic                                            clk,
  input  logic                                            resetn,
  input  logic                                            start,
  input  logic                                            user_ready,
  output logic                                            write_enable,
  output logic                                            read_enable,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]                          i_user_data,
  input  logic [DQ_BITWIDTH-1:0]                          o_user_data,
  input  logic                                            o_user_data_valid,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            pass,
  output logic                                            timeout,
  output logic [15:0]                                     error_count,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address
);

  localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST  = CW'(NUM_OF_TEST_DATA - 1);
  localparam logic [CW-1:0] NUM   = CW'(NUM_OF_TEST_DATA);
  localparam logic [AW-1:0] BASE  = AW'(START_ADDRESS);
  localparam logic [TW-1:0] TLIM  = TW'(TIMEOUT_CYCLES);

`ifdef CHECKER_LFSR_PATTERN_EN
  if (DQ_BITWIDTH != 16) begin : g_width_check
    $error("CHECKER_LFSR_PATTERN_EN requires DQ_BITWIDTH == 16");
  end
  localparam logic [DQ_BITWIDTH-1:0] SEED = DQ_BITWIDTH'(16'hACE1);
  // Fibonacci x^16+x^14+x^13+x^11+1, right shift with feedback into the MSB
  function automatic logic [DQ_BITWIDTH-1:0] pat_step(input logic [DQ_BITWIDTH-1:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[DQ_BITWIDTH-1:1]};
  endfunction
`else
  localparam logic [DQ_BITWIDTH-1:0] SEED = DQ_BITWIDTH'(1);
  function automatic logic [DQ_BITWIDTH-1:0] pat_step(input logic [DQ_BITWIDTH-1:0] s);
    return s + DQ_BITWIDTH'(1);
  endfunction
`endif

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT_DATA, S_DONE} state_t;

  typedef struct packed {
    logic                   we;
    logic                   re;
    logic [AW-1:0]          addr;
    logic [DQ_BITWIDTH-1:0] data;
  } req_t;

  state_t                 state_q, state_d;
  req_t                   req_q, req_d;
  logic [CW-1:0]          k_q, k_d, r_q, r_d, outst_q, outst_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [DQ_BITWIDTH-1:0] exp_q, exp_d;
  logic [15:0]            err_q, err_d;
  logic [AW-1:0]          ferr_addr_q, ferr_addr_d;
  logic                   ferr_vld_q, ferr_vld_d;
  logic                   tmo_q, tmo_d;
  logic                   pass_q, pass_d;

  logic wr_acc, rd_acc, beat_ok, spurious, mismatch;

  assign wr_acc   = req_q.we && user_ready;
  assign rd_acc   = req_q.re && user_ready;
  assign beat_ok  = o_user_data_valid && (outst_q != '0);
  assign spurious = o_user_data_valid && (outst_q == '0);
  assign mismatch = beat_ok && (o_user_data != exp_q);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    k_d         = k_q;
    r_d         = r_q;
    outst_d     = outst_q;
    exp_d       = exp_q;
    err_d       = err_q;
    ferr_addr_d = ferr_addr_q;
    ferr_vld_d  = ferr_vld_q;
    tmo_d       = tmo_q;
    timer_d     = (state_q == S_WAIT_DATA && !o_user_data_valid) ? timer_q + TW'(1) : '0;

    // read-data checking runs in every state so late or stray beats are still counted
    if (beat_ok) begin
      r_d   = r_q + CW'(1);
      exp_d = pat_step(exp_q);
    end
    if ((mismatch || spurious) && err_q != 16'hFFFF)
      err_d = err_q + 16'd1;
    if (mismatch && !ferr_vld_q) begin
      ferr_addr_d = BASE + AW'(r_q);
      ferr_vld_d  = 1'b1;
    end
    case ({rd_acc, beat_ok})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: ;
    endcase

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_WRITE;
          k_d         = '0;
          r_d         = '0;
          outst_d     = '0;
          exp_d       = SEED;
          err_d       = '0;
          ferr_addr_d = '0;
          ferr_vld_d  = 1'b0;
          tmo_d       = 1'b0;
          req_d       = '{we: 1'b1, re: 1'b0, addr: BASE, data: SEED};
        end
      end
      S_WRITE: begin
        if (wr_acc) begin
          if (k_q == LAST) begin
            state_d    = S_READ;
            k_d        = '0;
            req_d.we   = 1'b0;
            req_d.re   = 1'b1;
            req_d.addr = BASE;
          end else begin
            k_d        = k_q + CW'(1);
            req_d.addr = req_q.addr + AW'(1);
            req_d.data = pat_step(req_q.data);
          end
        end
      end
      S_READ: begin
        if (rd_acc) begin
          if (k_q == LAST) begin
            state_d  = S_WAIT_DATA;
            k_d      = '0;
            req_d.re = 1'b0;
          end else begin
            k_d        = k_q + CW'(1);
            req_d.addr = req_q.addr + AW'(1);
          end
        end
      end
      S_WAIT_DATA: begin
        if (r_q == NUM) begin
          state_d = S_DONE;
        end else if (timer_q == TLIM && !o_user_data_valid) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    pass_d = (state_d == S_DONE) && (err_d == '0) && !tmo_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      k_q         <= '0;
      r_q         <= '0;
      outst_q     <= '0;
      timer_q     <= '0;
      exp_q       <= '0;
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_vld_q  <= 1'b0;
      tmo_q       <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      k_q         <= k_d;
      r_q         <= r_d;
      outst_q     <= outst_d;
      timer_q     <= timer_d;
      exp_q       <= exp_d;
      err_q       <= err_d;
      ferr_addr_q <= ferr_addr_d;
      ferr_vld_q  <= ferr_vld_d;
      tmo_q       <= tmo_d;
      pass_q      <= pass_d;
    end
  end

  assign write_enable        = req_q.we;
  assign read_enable         = req_q.re;
  assign i_user_data_address = req_q.addr;
  assign i_user_data         = req_q.data;
  assign busy                = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_WAIT_DATA);
  assign done                = (state_q == S_DONE);
  assign pass                = pass_q;
  assign timeout             = tmo_q;
  assign error_count         = err_q;
  assign first_error_address = ferr_addr_q;

endmodule

// File: tb/tb_ddr3_loopback_checker.sv
// Directed bench for ddr3_loopback_checker with an in-bench memory model and request scoreboard.
module tb_ddr3_loopback_checker;
  localparam int AW  = 18;
  localparam int DW  = 16;
  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int TMO = 100;

`ifdef CHECKER_LFSR_PATTERN_EN
  localparam logic [DW-1:0] SEED = 16'hACE1;
`else
  localparam logic [DW-1:0] SEED = 16'h0001;
`endif

  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
  typedef struct {logic vld; logic [AW-1:0] addr;} slot_t;

  logic          clk = 1'b0, resetn = 1'b0, start = 1'b0, user_ready = 1'b0;
  logic          o_user_data_valid = 1'b0;
  logic [DW-1:0] o_user_data = '0;
  logic          write_enable, read_enable, busy, done, pass, timeout;
  logic [AW-1:0] i_user_data_address, first_error_address;
  logic [DW-1:0] i_user_data;
  logic [15:0]   error_count;

  int checks = 0, errors = 0, cyc = 0;
  wr_t           exp_wr[$];
  logic [AW-1:0] exp_rd[$];
  slot_t         pipe[LAT];
  logic [DW-1:0] mem[16];
  int ready_mode = 0, corrupt_addr = -1, drop_idx = -1, beat_num = 0, last_beat_cyc = 0;
  bit extra_beat = 1'b0;
  logic [AW+DW+1:0] prev_req = '0;
  logic prev_ready = 1'b0;

  ddr3_loopback_checker #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn), .start(start), .user_ready(user_ready),
    .write_enable(write_enable), .read_enable(read_enable),
    .i_user_data_address(i_user_data_address), .i_user_data(i_user_data),
    .o_user_data(o_user_data), .o_user_data_valid(o_user_data_valid),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .error_count(error_count), .first_error_address(first_error_address)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat_next(input logic [DW-1:0] s);
`ifdef CHECKER_LFSR_PATTERN_EN
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[DW-1:1]};
`else
    return s + 16'd1;
`endif
  endfunction

  // One cycle: at the falling edge drive inputs for the next rising edge and model the memory.
  task automatic step();
    slot_t            out;
    wr_t              e;
    logic [AW+DW+1:0] cur;
    @(negedge clk);
    cyc++;
    user_ready = (ready_mode == 0) || (cyc % 3 == 0);
    cur = {write_enable, read_enable, i_user_data_address, i_user_data};
    if (resetn && (prev_req[AW+DW+1] || prev_req[AW+DW]) && !prev_ready)
      chk("req_hold", cur, prev_req);
    prev_req   = cur;
    prev_ready = user_ready;
    out = pipe[LAT-1];
    for (int i = LAT-1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = '{1'b0, '0};
    if (!resetn) begin
      for (int i = 0; i < LAT; i++) pipe[i] = '{1'b0, '0};
      out.vld = 1'b0;
    end else begin
      if (write_enable && user_ready) begin
        chk("wr_pending", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          chk("wr_addr", i_user_data_address, e.addr);
          chk("wr_data", i_user_data, e.data);
        end
        mem[i_user_data_address[3:0]] = i_user_data;
      end
      if (read_enable && user_ready) begin
        chk("rd_pending", exp_rd.size() > 0, 1);
        if (exp_rd.size() > 0) chk("rd_addr", i_user_data_address, exp_rd.pop_front());
        pipe[0] = '{1'b1, i_user_data_address};
      end
    end
    o_user_data_valid = 1'b0;
    if (out.vld) begin
      if (beat_num != drop_idx) begin
        o_user_data_valid = 1'b1;
        o_user_data = (int'(out.addr) == corrupt_addr) ? '0 : mem[out.addr[3:0]];
        last_beat_cyc = cyc;
      end
      beat_num++;
    end else if (extra_beat) begin
      o_user_data_valid = 1'b1;
      o_user_data = 16'h5555;
      extra_beat = 1'b0;
    end
  endtask

  task automatic start_pass();
    logic [DW-1:0] d;
    d = SEED;
    exp_wr.delete();
    exp_rd.delete();
    beat_num = 0;
    for (int k = 0; k < N; k++) begin
      exp_wr.push_back('{AW'(k), d});
      exp_rd.push_back(AW'(k));
      d = pat_next(d);
    end
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int took);
    took = 0;
    while (!done && took < budget) begin
      step();
      took++;
    end
    chk("done_reached", done, 1);
  endtask

  initial begin
    int took, gap;
    for (int i = 0; i < LAT; i++) pipe[i] = '{1'b0, '0};
    repeat (3) step();
    chk("rst_we", write_enable, 0);
    chk("rst_re", read_enable, 0);
    chk("rst_addr", i_user_data_address, 0);
    chk("rst_data", i_user_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err", error_count, 0);
    chk("rst_ferr", first_error_address, 0);
    resetn = 1'b1;
    step();

    // clean pass, always ready
    start_pass();
    chk("s1_busy", busy, 1);
    wait_done(40, took);
    chk("s1_within_20", took <= 20, 1);
    chk("s1_pass", pass, 1);
    chk("s1_err", error_count, 0);
    chk("s1_timeout", timeout, 0);
    chk("s1_wr_left", exp_wr.size(), 0);
    chk("s1_rd_left", exp_rd.size(), 0);

    // stray beat while done
    extra_beat = 1'b1;
    step();
    step();
    chk("sp_err", error_count, 1);
    chk("sp_pass", pass, 0);
    chk("sp_done", done, 1);
    chk("sp_ferr", first_error_address, 0);

    // start clears the stray count; ready asserted 1 cycle in 3
    ready_mode = 1;
    start_pass();
    chk("s2_err_clr", error_count, 0);
    chk("s2_done_clr", done, 0);
    chk("s2_busy", busy, 1);
    wait_done(150, took);
    chk("s2_pass", pass, 1);
    chk("s2_err", error_count, 0);
    chk("s2_wr_left", exp_wr.size(), 0);
    chk("s2_rd_left", exp_rd.size(), 0);

    // corrupt the word at address 2
    ready_mode = 0;
    corrupt_addr = 2;
    start_pass();
    wait_done(40, took);
    chk("s3_err", error_count, 1);
    chk("s3_ferr", first_error_address, 2);
    chk("s3_pass", pass, 0);
    chk("s3_timeout", timeout, 0);
    corrupt_addr = -1;

    // fourth beat never returns
    drop_idx = 3;
    start_pass();
    wait_done(300, took);
    gap = cyc - last_beat_cyc;
    chk("s4_timeout", timeout, 1);
    chk("s4_pass", pass, 0);
    chk("s4_err", error_count, 0);
    chk("s4_gap_lo", gap >= TMO - 2, 1);
    chk("s4_gap_hi", gap <= TMO + 6, 1);
    drop_idx = -1;

    // reset in the middle of the read phase
    start_pass();
    took = 0;
    while (!read_enable && took < 50) begin
      step();
      took++;
    end
    chk("s6_in_read", read_enable, 1);
    resetn = 1'b0;
    #1;
    chk("s6_rst_re", read_enable, 0);
    chk("s6_rst_we", write_enable, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_done", done, 0);
    chk("s6_rst_addr", i_user_data_address, 0);
    step();
    step();
    resetn = 1'b1;
    step();
    start_pass();
    wait_done(40, took);
    chk("s6_pass", pass, 1);
    chk("s6_err", error_count, 0);
    chk("s6_wr_left", exp_wr.size(), 0);
    chk("s6_rd_left", exp_rd.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
